traffic_phase_controller: RTL and testbench

//  Sequences one shared light-phase down-counter through a two-road (NS/EW) intersection cycle.
//  Per phase: drives the counter's load strobe and load value, consumes its expiry tick, advances the phase FSM.

---
 rtl/traffic_phase_controller.sv | 147 ++++++++++++++
 tb/tb_traffic_phase_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : traffic_phase_controller                                     |
// | Description : NS/EW intersection phase FSM driving a shared down-counter;  |
// |               optional pedestrian WALK phase under macro PED_REQ_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module traffic_phase_controller #(
    parameter int pGreen_Count_Sec  = 15,
    parameter int pYellow_Count_Sec = 3,
    parameter int pAllRed_Count_Sec = 1,
    parameter int pWalk_Count_Sec   = 8,
    parameter int pCount_width      = $clog2(pGreen_Count_Sec + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sec_tick,
    input  logic                    light_tick,
`ifdef PED_REQ_EN
    input  logic                    ped_req,
    output logic                    walk,
`endif
    output logic                    ctr_load,
    output logic [pCount_width-1:0] load_count,
    output logic [2:0]              ns_light,
    output logic [2:0]              ew_light,
    output logic [2:0]              phase
);

    typedef enum logic [2:0] {
        ALLR_A = 3'd0,
        NS_G   = 3'd1,
        NS_Y   = 3'd2,
        ALLR_B = 3'd3,
        EW_G   = 3'd4,
        EW_Y   = 3'd5,
        WALK   = 3'd6
    } state_t;

    localparam logic [2:0] c_red = 3'b100;
    localparam logic [2:0] c_yel = 3'b010;
    localparam logic [2:0] c_grn = 3'b001;

    localparam logic [pCount_width-1:0] c_green_ld  = pCount_width'(pGreen_Count_Sec - 1);
    localparam logic [pCount_width-1:0] c_yellow_ld = pCount_width'(pYellow_Count_Sec - 1);
    localparam logic [pCount_width-1:0] c_allred_ld = pCount_width'(pAllRed_Count_Sec - 1);
    localparam logic [pCount_width-1:0] c_walk_ld   = pCount_width'(pWalk_Count_Sec - 1);

    state_t r_state;
    state_t w_next;
    logic   r_init_pend;
    logic   w_expire;
    logic   w_adv;
    logic   w_req;
    logic   w_walk_to_ew;

    function automatic logic [pCount_width-1:0] dur_m1(input state_t s);
        case (s)
            NS_G, EW_G: dur_m1 = c_green_ld;
            NS_Y, EW_Y: dur_m1 = c_yellow_ld;
            WALK:       dur_m1 = c_walk_ld;
            default:    dur_m1 = c_allred_ld;
        endcase
    endfunction

    // Returns {ns_light, ew_light}
    function automatic logic [5:0] lamps(input state_t s);
        case (s)
            NS_G:    lamps = {c_grn, c_red};
            NS_Y:    lamps = {c_yel, c_red};
            EW_G:    lamps = {c_red, c_grn};
            EW_Y:    lamps = {c_red, c_yel};
            default: lamps = {c_red, c_red};
        endcase
    endfunction

`ifdef PED_REQ_EN
    logic r_req_pend;
    logic r_walk_to_ew;
    assign w_req        = r_req_pend;
    assign w_walk_to_ew = r_walk_to_ew;
`else
    assign w_req        = 1'b0;
    assign w_walk_to_ew = 1'b0;
`endif

    // Expiry only counts once the counter has been resynchronised after reset
    assign w_expire = sec_tick & light_tick & ~r_init_pend;
    assign w_adv    = en & w_expire;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ALLR_A:  w_next = w_req ? WALK : NS_G;
            NS_G:    w_next = NS_Y;
            NS_Y:    w_next = ALLR_B;
            ALLR_B:  w_next = w_req ? WALK : EW_G;
            EW_G:    w_next = EW_Y;
            EW_Y:    w_next = ALLR_A;
            WALK:    w_next = w_walk_to_ew ? EW_G : NS_G;
            default: w_next = ALLR_A;
        endcase
    end

    assign ctr_load   = ~rst & en & sec_tick & (light_tick | r_init_pend);
    assign load_count = dur_m1(w_expire ? w_next : r_state);
    assign phase      = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ALLR_A;
            r_init_pend <= 1'b1;
            ns_light    <= c_red;
            ew_light    <= c_red;
`ifdef PED_REQ_EN
            r_req_pend   <= 1'b0;
            r_walk_to_ew <= 1'b0;
            walk         <= 1'b0;
`endif
        end else begin
            if (en && sec_tick) begin
                r_init_pend <= 1'b0;
            end
            if (w_adv) begin
                r_state              <= w_next;
                {ns_light, ew_light} <= lamps(w_next);
            end
`ifdef PED_REQ_EN
            // A new request arriving on the clearing edge must survive
            if (ped_req) begin
                r_req_pend <= 1'b1;
            end else if (w_adv && w_next == WALK) begin
                r_req_pend <= 1'b0;
            end
            if (w_adv && w_next == WALK) begin
                r_walk_to_ew <= (r_state == ALLR_B);
            end
            if (w_adv) begin
                walk <= (w_next == WALK);
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_traffic_phase_controller                                  |
// | Description : Directed bench for traffic_phase_controller with a model of  |
// |               the external light down-counter.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_traffic_phase_controller;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b1;
    logic       sec_tick = 1'b0;
    logic       light_tick;
    logic       ctr_load;
    logic [3:0] load_count;
    logic [3:0] cnt = 4'd0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
`ifdef PED_REQ_EN
    logic       ped_req = 1'b0;
    logic       walk;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    bit         mon_on   = 1'b0;
    logic       ld;
    logic [3:0] lc;

    always #5 clk = ~clk;

    // External light counter: loads on strobe, counts down on enabled seconds
    assign light_tick = sec_tick && (cnt == 4'd0);
    always @(posedge clk) begin
        if (ctr_load) cnt <= load_count;
        else if (en && sec_tick && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    traffic_phase_controller dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sec_tick   (sec_tick),
        .light_tick (light_tick),
`ifdef PED_REQ_EN
        .ped_req    (ped_req),
        .walk       (walk),
`endif
        .ctr_load   (ctr_load),
        .load_count (load_count),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .phase      (phase)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        sec_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One second: sec_tick high for one clk, 10 clk total; samples the load strobe
    task automatic sec_pulse(input logic with_rst);
        @(negedge clk);
        sec_tick = 1'b1;
        rst      = with_rst;
        #1;
        ld = ctr_load;
        lc = load_count;
        @(negedge clk);
        sec_tick = 1'b0;
        rst      = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [5:0] exp_lamps(input logic [2:0] p);
        case (p)
            3'd1:    return 6'b001_100;
            3'd2:    return 6'b010_100;
            3'd4:    return 6'b100_001;
            3'd5:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    function automatic logic [2:0] exp_phase_t1(input int n);
        if (n < 2)  return 3'd0;
        if (n < 17) return 3'd1;
        if (n < 20) return 3'd2;
        if (n < 21) return 3'd3;
        if (n < 36) return 3'd4;
        if (n < 39) return 3'd5;
        if (n < 40) return 3'd0;
        return 3'd1;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            check_eq("ns_onehot", 32'($onehot(ns_light)), 32'd1);
            check_eq("ew_onehot", 32'($onehot(ew_light)), 32'd1);
            check_eq("one_road_red", 32'(ns_light[2] | ew_light[2]), 32'd1);
        end
    end

    initial begin
        logic       eld;
        logic [3:0] elc;

        // T1: reset state and a full cycle
        do_reset();
        mon_on = 1'b1;
        check_eq("rst_phase", 32'(phase), 32'd0);
        check_eq("rst_ns", 32'(ns_light), 32'd4);
        check_eq("rst_ew", 32'(ew_light), 32'd4);
        check_eq("rst_ctr_load", 32'(ctr_load), 32'd0);
        for (int n = 1; n <= 40; n++) begin
            sec_pulse(1'b0);
            eld = 1'b1;
            case (n)
                1, 20, 39: elc = 4'd0;
                2, 21, 40: elc = 4'd14;
                17, 36:    elc = 4'd2;
                default: begin eld = 1'b0; elc = 4'd0; end
            endcase
            check_eq($sformatf("t1_ld_%0d", n), 32'(ld), 32'(eld));
            if (eld) check_eq($sformatf("t1_lc_%0d", n), 32'(lc), 32'(elc));
            check_eq($sformatf("t1_phase_%0d", n), 32'(phase), 32'(exp_phase_t1(n)));
            check_eq($sformatf("t1_lamps_%0d", n), 32'({ns_light, ew_light}),
                     32'(exp_lamps(exp_phase_t1(n))));
        end

        // T2: freeze mid NS_G, then resume with no lost or extra seconds
        repeat (2) sec_pulse(1'b0);
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            sec_pulse(1'b0);
            check_eq("t2_frozen_ld", 32'(ld), 32'd0);
            check_eq("t2_frozen_phase", 32'(phase), 32'd1);
            check_eq("t2_frozen_ns", 32'(ns_light), 32'd1);
        end
        en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            sec_pulse(1'b0);
            check_eq("t2_hold_phase", 32'(phase), 32'd1);
            check_eq("t2_hold_ld", 32'(ld), 32'd0);
        end
        sec_pulse(1'b0);
        check_eq("t2_exit_ld", 32'(ld), 32'd1);
        check_eq("t2_exit_lc", 32'(lc), 32'd2);
        check_eq("t2_exit_phase", 32'(phase), 32'd2);

        // T3: reset coinciding with EW_Y expiry
        do_reset();
        repeat (38) sec_pulse(1'b0);
        check_eq("t3_pre_phase", 32'(phase), 32'd5);
        sec_pulse(1'b1);
        check_eq("t3_rst_ld", 32'(ld), 32'd0);
        check_eq("t3_rst_phase", 32'(phase), 32'd0);
        check_eq("t3_rst_ns", 32'(ns_light), 32'd4);
        check_eq("t3_rst_ew", 32'(ew_light), 32'd4);
        sec_pulse(1'b0);
        check_eq("t3_init_ld", 32'(ld), 32'd1);
        check_eq("t3_init_lc", 32'(lc), 32'd0);
        check_eq("t3_init_phase", 32'(phase), 32'd0);
        sec_pulse(1'b0);
        check_eq("t3_next_ld", 32'(ld), 32'd1);
        check_eq("t3_next_lc", 32'(lc), 32'd14);
        check_eq("t3_next_phase", 32'(phase), 32'd1);

`ifdef PED_REQ_EN
        // T4/T5: request in NS_G gives WALK after ALLR_B; request in WALK gives WALK after ALLR_A
        do_reset();
        for (int n = 1; n <= 56; n++) begin
            logic [2:0] ep;
            sec_pulse(1'b0);
            if      (n < 2)  ep = 3'd0;
            else if (n < 17) ep = 3'd1;
            else if (n < 20) ep = 3'd2;
            else if (n < 21) ep = 3'd3;
            else if (n < 29) ep = 3'd6;
            else if (n < 44) ep = 3'd4;
            else if (n < 47) ep = 3'd5;
            else if (n < 48) ep = 3'd0;
            else if (n < 56) ep = 3'd6;
            else             ep = 3'd1;
            check_eq($sformatf("ped_phase_%0d", n), 32'(phase), 32'(ep));
            check_eq($sformatf("ped_walk_%0d", n), 32'(walk), 32'(ep == 3'd6));
            if (n == 21 || n == 48) check_eq($sformatf("ped_lc_%0d", n), 32'(lc), 32'd7);
            if (n == 29 || n == 56) check_eq($sformatf("ped_lc_%0d", n), 32'(lc), 32'd14);
            if (n == 5 || n == 23) begin
                @(negedge clk);
                ped_req = 1'b1;
                @(negedge clk);
                ped_req = 1'b0;
            end
        end
`endif

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
